// File: rtl/conv_pe_pkg.sv
// Shared constants and width helpers for the conv PE and the pooling stage.
package conv_pe_pkg;

  localparam int KSZ  = 3;
  localparam int TAPS = KSZ * KSZ;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision accumulator: one product width plus growth for every tap.
  function automatic int acc_width(input int dw, input int ch);
    return 2 * dw + clog2(TAPS * ch);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: the output is the word shifted in DEPTH enables earlier.
module conv_line_buffer #(
  parameter int W     = 27,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_pe_stream.sv
// Streaming 3x3 multi-channel convolution PE: line buffers, window, products,
// accumulation and optional ReLU in a three-stage pipeline that stalls as one.
module conv_pe_stream
  import conv_pe_pkg::*;
#(
  parameter int  DW   = 9,
  parameter int  CH   = 3,
  parameter int  COLS = 32,
  parameter int  ROWS = 32,
  parameter int  AW   = acc_width(DW, CH),
  localparam int NT   = TAPS * CH,
  localparam int WAW  = clog2(NT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_load,
  output logic             w_ready,
  input  logic [WAW-1:0]   w_addr,
  input  logic [DW-1:0]    w_data,
  input  logic             relu_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CH*DW-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [AW-1:0]    m_data,
  output logic             frame_err
);

  localparam int PW = CH * DW;
  localparam int CW = clog2(COLS);
  localparam int RW = clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic          adv;
  logic          accept;
  logic          busy;
  logic          last_pos;
  logic          in_range;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] lb1_q;
  logic [PW-1:0] lb2_q;
  logic [PW-1:0] row_px [KSZ];
  logic          v1;
  logic          v2;

  logic signed [DW-1:0]   win  [NT];
  logic signed [DW-1:0]   wgt  [NT];
  logic signed [2*DW-1:0] prod [NT];
  logic signed [AW-1:0]   psum [NT+1];
  logic signed [AW-1:0]   total;

  assign adv      = !m_valid || m_ready;
  assign s_ready  = adv;
  assign accept   = s_valid && adv;
  assign busy     = (row != '0) || (col != '0) || v1 || v2 || m_valid;
  assign w_ready  = !busy;
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);
  assign in_range = (row >= RW'(2)) && (col >= CW'(2));

  // Pixel position; an early s_last resyncs so the next pixel starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (s_last && !last_pos) begin
        frame_err <= 1'b1;
        row       <= '0;
        col       <= '0;
      end else if (last_pos) begin
        if (!s_last) frame_err <= 1'b1;
        row <= '0;
        col <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) wgt[i] <= '0;
    end else if (w_load && w_ready && (w_addr < WAW'(NT))) begin
      wgt[w_addr] <= w_data;
    end
  end

  conv_line_buffer #(.W(PW), .DEPTH(COLS)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (s_data),
    .dout (lb1_q)
  );

  conv_line_buffer #(.W(PW), .DEPTH(COLS)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  assign row_px[0] = lb2_q;
  assign row_px[1] = lb1_q;
  assign row_px[2] = s_data;

  // Window taps ordered ch*9 + ky*3 + kx; kx=2 is the newest column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        for (int ky = 0; ky < KSZ; ky++) begin
          win[c*TAPS + ky*KSZ + 0] <= win[c*TAPS + ky*KSZ + 1];
          win[c*TAPS + ky*KSZ + 1] <= win[c*TAPS + ky*KSZ + 2];
          win[c*TAPS + ky*KSZ + 2] <= row_px[ky][c*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < NT; i++) prod[i] <= win[i] * wgt[i];
    end
  end

  assign psum[0] = '0;
  for (genvar i = 0; i < NT; i++) begin : g_acc
    assign psum[i+1] = psum[i] + {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
  end
  assign total = psum[NT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (adv) begin
      v1      <= accept && in_range;
      v2      <= v1;
      m_valid <= v2;
      if (v2) m_data <= (relu_en && total[AW-1]) ? '0 : total;
    end
  end

endmodule

// File: tb/tb_conv_pe_stream.sv
// Scoreboard bench for conv_pe_stream on a 5x4, 3-channel frame.
module tb_conv_pe_stream;
  import conv_pe_pkg::*;

  localparam int DW   = 9;
  localparam int CH   = 3;
  localparam int COLS = 5;
  localparam int ROWS = 4;
  localparam int NT   = TAPS * CH;
  localparam int AW   = acc_width(DW, CH);
  localparam int WAW  = clog2(NT);

  logic             clk;
  logic             rst;
  logic             w_load;
  logic             w_ready;
  logic [WAW-1:0]   w_addr;
  logic [DW-1:0]    w_data;
  logic             relu_en;
  logic             s_valid;
  logic             s_ready;
  logic [CH*DW-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [AW-1:0]    m_data;
  logic             frame_err;

  conv_pe_stream #(.DW(DW), .CH(CH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_load    (w_load),
    .w_ready   (w_ready),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .relu_en   (relu_en),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  int out_cnt = 0;
  int acc_cnt = 0;
  int tries = 0;
  int wm [NT];
  int img [ROWS][COLS][CH];
  int mr = 0;
  int mc = 0;
  int exp_err = 0;
  int relu = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int pix_val(input int mode, input int r, input int c, input int ch);
    case (mode)
      0:       return (ch == 0) ? 1 : 0;
      1:       return c % 3;
      2:       return 1;
      default: return ((c + 2*r + ch) % 3) + 1;
    endcase
  endfunction

  function automatic int w_val(input int mode, input int t);
    int ch, ky, kx;
    ch = t / 9;
    ky = (t % 9) / 3;
    kx = t % 3;
    case (mode)
      0:       return (ch == 0) ? 1 : 0;
      1:       return ky + kx + ch;
      default: return -1;
    endcase
  endfunction

  // Output monitor: a transfer happens at the next rising edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_data", int'($signed(m_data)), e);
        end
        out_cnt++;
      end
    end
  end

  task automatic load_w(input int mode);
    int val;
    for (int t = 0; t < NT; t++) begin
      @(negedge clk);
      val    = w_val(mode, t);
      w_load = 1'b1;
      w_addr = WAW'(t);
      w_data = val[DW-1:0];
      #1;
      chk("w_ready_idle", int'(w_ready), 1);
      wm[t] = val;
      @(posedge clk);
    end
    @(negedge clk);
    w_load = 1'b0;
  endtask

  task automatic send_px(input int dm, input bit last);
    logic [CH*DW-1:0] d;
    int v [CH];
    int k, e;
    bit ok;
    bit lp;
    for (int c = 0; c < CH; c++) begin
      v[c] = pix_val(dm, mr, mc, c);
      d[c*DW +: DW] = v[c][DW-1:0];
    end
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 60) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      #1;
      ok = s_ready;
      @(posedge clk);
      k++;
    end
    tries += k;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      acc_cnt++;
      for (int c = 0; c < CH; c++) img[mr][mc][c] = v[c];
      if (mr >= 2 && mc >= 2) begin
        e = 0;
        for (int c = 0; c < CH; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              e += img[mr-2+ky][mc-2+kx][c] * wm[c*9 + ky*3 + kx];
        if (relu != 0 && e < 0) e = 0;
        q.push_back(e);
      end
      lp = (mr == ROWS-1) && (mc == COLS-1);
      if (last && !lp) begin
        exp_err = 1;
        mr = 0;
        mc = 0;
      end else if (lp) begin
        if (!last) exp_err = 1;
        mr = 0;
        mc = 0;
      end else if (mc == COLS-1) begin
        mc = 0;
        mr++;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic send_frame(input int dm, input int n, input int last_idx);
    for (int i = 0; i < n; i++) send_px(dm, i == last_idx);
  endtask

  task automatic stop_in();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    chk("idle_mvalid", int'(m_valid), 0);
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    exp_err = 0;
    for (int t = 0; t < NT; t++) wm[t] = 0;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int o0, t0, a0, held, k;
    rst = 1'b1; w_load = 1'b0; w_addr = '0; w_data = '0; relu_en = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'($signed(m_data)), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_w_ready", int'(w_ready), 1);

    // ch0 ones only
    load_w(0);
    o0 = out_cnt;
    send_frame(0, 20, 19);
    stop_in();
    drain();
    chk("t1_count", out_cnt - o0, 6);
    chk("t1_err", int'(frame_err), exp_err);

    // ky+kx+ch weights, three frames back-to-back
    load_w(1);
    o0 = out_cnt;
    t0 = tries;
    for (int f = 0; f < 3; f++) send_frame(1, 20, 19);
    stop_in();
    chk("t2_no_stall", tries - t0, 60);
    drain();
    chk("t2_count", out_cnt - o0, 18);

    // negative sums, ReLU off then on
    load_w(2);
    o0 = out_cnt;
    send_frame(2, 20, 19);
    stop_in();
    drain();
    relu_en = 1'b1;
    relu = 1;
    send_frame(2, 20, 19);
    stop_in();
    drain();
    relu_en = 1'b0;
    relu = 0;
    chk("t3_count", out_cnt - o0, 12);

    // downstream stall mid-frame
    load_w(1);
    o0 = out_cnt;
    fork
      begin
        send_frame(3, 20, 19);
        stop_in();
      end
      begin
        k = 0;
        @(negedge clk);
        while (!m_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        chk("t4_mvalid", int'(m_valid), 1);
        m_ready = 1'b0;
        held = int'($signed(m_data));
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
          #1;
          chk("t4_s_ready", int'(s_ready), 0);
          chk("t4_hold", int'($signed(m_data)), held);
          chk("t4_mvalid_hold", int'(m_valid), 1);
          chk("t4_no_accept", acc_cnt, a0);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", out_cnt - o0, 6);

    // early s_last, then missing s_last
    o0 = out_cnt;
    send_frame(3, 8, 7);
    stop_in();
    #1;
    chk("t5_err_early", int'(frame_err), 1);
    send_frame(3, 20, 19);
    stop_in();
    drain();
    chk("t5_count", out_cnt - o0, 6);
    chk("t5_err_sticky", int'(frame_err), exp_err);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_err_clear", int'(frame_err), 0);
    load_w(1);
    o0 = out_cnt;
    send_frame(3, 20, -1);
    stop_in();
    #1;
    chk("t5_err_nolast", int'(frame_err), 1);
    drain();
    chk("t5_count2", out_cnt - o0, 6);

    // weight write while busy is ignored
    o0 = out_cnt;
    fork
      begin
        send_frame(3, 20, 19);
        stop_in();
      end
      begin
        repeat (6) @(negedge clk);
        w_load = 1'b1;
        w_addr = '0;
        w_data = 9'd50;
        #1;
        chk("t6_w_ready_busy", int'(w_ready), 0);
        @(negedge clk);
        w_load = 1'b0;
      end
    join
    drain();
    send_frame(3, 20, 19);
    stop_in();
    drain();
    chk("t6_count", out_cnt - o0, 12);

    // reset mid-frame drops partial work and clears weights
    send_frame(2, 13, -1);
    stop_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t7_m_valid", int'(m_valid), 0);
    chk("t7_w_ready", int'(w_ready), 1);
    chk("t7_s_ready", int'(s_ready), 1);
    o0 = out_cnt;
    send_frame(2, 20, 19);
    stop_in();
    drain();
    chk("t7_count", out_cnt - o0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pe_stream.md
# conv_pe_stream

Streaming 3x3 convolution processing element and the parametrised successor to the fixed 9-bit, 3-channel, 32-column conv PE. It accepts one multi-channel pixel per cycle in raster order over a valid/ready stream. Two internal line buffers build the 3x3 window. Per cycle it produces one signed multiply-accumulate result summed across all channels, with optional ReLU. Weights are loaded at run time through a handshaked write port, and it sits between the feature-map fetch unit and the pooling stage.

## Interface
- DW, 9: data and weight width, signed two's complement
- CH, 3: input channels summed into one output
- COLS, 32: pixels per row
- ROWS, 32: rows per frame
- AW, 2*DW+clog2(9*CH): accumulator/output width (default 23)
- clk  in  1  clock
- rst  in  1  one clock clk; reset rst is synchronous and active-high
- w_load  in  1  weight write request
- w_ready  out  1  weight write accepted when high
- w_addr  in  clog2(9*CH)  tap index = ch*9 + ky*3 + kx
- w_data  in  DW  signed weight
- relu_en  in  1  clamp negative results to 0
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&s_ready
- s_data  in  CH*DW  channel c at bits [c*DW +: DW]
- s_last  in  1  marks final pixel of frame
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts
- m_data  out  AW  signed result
- frame_err  out  1  sticky s_last mismatch flag

## Operation
- Column counter runs 0..COLS-1; row counter runs 0..ROWS-1. Both advance only on an accepted pixel and wrap to (0,0) after pixel (ROWS-1, COLS-1).
- Line buffers hold the previous two rows. For each channel, the window shifts in {row-2, row-1, current} on every accepted pixel.
- Valid-only convolution, no padding. An output is generated only for accepted pixels with row>=2 and col>=2, giving (ROWS-2)*(COLS-2) outputs per frame. Stale line-buffer data from the previous frame is never emitted.
- The window is anchored at the accepted pixel (r,c). It covers rows r-2..r and cols c-2..c. Tap (ky,kx) multiplies pixel (r-2+ky, c-2+kx).
- Result = sum over ch, ky, kx of data*weight. All products are signed 2*DW bits and sign-extended to AW, so no overflow is possible.
- ReLU is applied when relu_en, sampled in the final stage, is 1 and the result is negative; the output is then 0.
- s_last on a pixel that is not (ROWS-1, COLS-1) sets frame_err, and the counters resync to (0,0) for the next pixel. Pixel (ROWS-1, COLS-1) without s_last also sets frame_err; the counters wrap normally.
- frame_err clears only on rst.
- busy = counters not at (0,0), or any pipeline stage valid.
- w_ready = !busy. A write occurs when w_load&w_ready; w_load while busy is ignored and the weight is unchanged.

## Timing
- Reset values: m_valid 0, m_data 0, frame_err 0, s_ready 1, w_ready 1. Counters, weights and pipeline valid bits are 0; line-buffer contents are don't-care.
- Pipeline: the accepting edge loads the window (S1), then products (S2), then adder tree + ReLU into the m_data register (S3).
- An output-producing pixel accepted at edge t drives m_valid=1 after edge t+2, three register stages later, when there are no stalls.
- The pipeline advances as a whole when adv = !m_valid | m_ready.
- s_ready = adv, combinational from m_valid/m_ready only; it does not depend on s_valid.
- m_valid/m_data are held stable while m_valid & !m_ready.
- Simultaneous m_ready-drain and s_valid accept is allowed, sustaining one result per cycle.
- A weight written at edge t is used by every window accepted after edge t.
- rst mid-frame: all valid bits and counters are 0 after the reset edge and partial results are dropped. The next pixel is treated as (0,0).

## Structure
- Package conv_pe_pkg: KSZ=3, TAPS=9, a clog2 function and an AW-derivation function, shared with the pooling stage.
- Sub-module conv_line_buffer: depth COLS, width CH*DW, with shift enable, instanced twice.
- Multipliers and the adder tree stay inline. The tree is a generate loop over 9*CH taps.

## Test plan
- COLS=5, ROWS=4, CH=3, ch0 weights all 1, others 0, every pixel ch0=1 -> exactly 6 outputs, each 9; frame_err=0.
- Weight w=ky+kx+ch (0..6 pattern), pixel values 0/1/2 cycling per column, CH=3 -> every output matches a scoreboard model. Cycle 3 streams frames back-to-back with no gap and no result loss.
- Weights all -1, data all 1 -> relu_en=0 gives -27 per output; relu_en=1 gives 0.
- Hold m_ready=0 for 5 cycles mid-frame -> s_ready=0 while m_valid is held, m_data stable, no pixel accepted. Output order and count are unchanged after release.
- s_last on pixel 7 of a 5x4 frame -> frame_err=1, next pixel is (0,0), no output until new row 2, col 2. Omitting s_last on the final pixel also sets frame_err.
- w_load mid-frame -> w_ready=0 and weight unchanged, as confirmed on the next frame. Assert rst mid-frame -> next cycle m_valid=0, w_ready=1, weights read back as 0 (all outputs 0).
